mem_lsu: RTL and testbench

- Memory-stage load/store unit, between the ex_mem pipeline register (upstream) and mem_wb (downstream).
- Takes one memory op from ex_mem and performs it on a req/gnt/rvalid data bus, stalling the pipe meanwhile.
- Drives the mem_rd_* result fields, which mem_wb captures every cycle. Its write enable is always 1, so mem_lsu must present each result for exactly one cycle and a bubble (rd_en=0) at all other times.

---
 rtl/mem_lsu_pkg.sv | 54 +++++
 rtl/mem_lsu_align.sv | 61 ++++++
 rtl/mem_lsu.sv | 209 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_pkg
//  Description : Shared definitions for the memory-stage load/store unit:
//                op-field layout, access sizes, FSM state encodings and the
//                address helpers used at op acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    localparam int REG_IDX_WIDTH = 5;

    // lsu_op = {is_store, is_unsigned, size[1:0]}
    localparam int LSU_OP_WIDTH = 4;
    localparam int LSU_ST_BIT   = 3;
    localparam int LSU_UNS_BIT  = 2;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_WAIT = 2'd2;

    // Byte lane actually used by an access. Halfword and word accesses
    // drop the low address bits that would make them misaligned, so an
    // unaligned op executes on its naturally aligned container.
    function automatic logic [1:0] lsu_lane_offset(input logic [1:0] size,
                                                   input logic [1:0] addr_lo);
        logic [1:0] off;
        case (size)
            LSU_SIZE_B: off = addr_lo;
            LSU_SIZE_H: off = {addr_lo[1], 1'b0};
            default:    off = 2'b00;
        endcase
        return off;
    endfunction

    // True when the access is not naturally aligned for its size.
    // The reserved size encoding is treated like a word.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LSU_SIZE_B: mis = 1'b0;
            LSU_SIZE_H: mis = addr_lo[0];
            default:    mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_align
//  Description : Combinational lane logic shared by the load/store paths.
//                Store side: replicates the low byte/half across all lanes
//                and generates byte strobes. Load side: picks the addressed
//                byte/half out of the read word and zero/sign extends it.
//  Ports       : size, is_unsigned, offset  - access descriptor (offset is
//                                             already size-aligned)
//                sdata -> wdata, wstrb      - store lane generation
//                rdata -> ldata             - load extract/extend
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] sdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] ldata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{offset, 3'b000} +: 8];
    assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        wdata = sdata;
        wstrb = 4'hF;
        ldata = rdata;
        case (size)
            LSU_SIZE_B: begin
                wdata = {(XLEN/8){sdata[7:0]}};
                wstrb = 4'b0001 << offset;
                ldata = is_unsigned ? {{(XLEN-8){1'b0}}, byte_sel}
                                    : {{(XLEN-8){byte_sel[7]}}, byte_sel};
            end
            LSU_SIZE_H: begin
                wdata = {(XLEN/16){sdata[15:0]}};
                wstrb = 4'b0011 << offset;
                ldata = is_unsigned ? {{(XLEN-16){1'b0}}, half_sel}
                                    : {{(XLEN-16){half_sel[15]}}, half_sel};
            end
            default: begin
                wdata = sdata;
                wstrb = 4'hF;
                ldata = rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : Memory-stage load/store unit. Accepts one op from ex_mem,
//                runs it on a req/gnt/rvalid data bus while stalling the
//                pipe, and presents the load result to mem_wb for exactly
//                one cycle (bubble otherwise). A bus response that does not
//                arrive within MAX_WAIT cycles of the grant raises a
//                one-cycle lsu_err_o and frees the pipe.
//  Options     : LSU_MISALIGN_EXC_EN - when defined, misaligned H/W ops are
//                rejected in the accept cycle with an lsu_err_o pulse;
//                otherwise their low address bits are forced to zero.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                ex_mem_*            - op from the ex_mem register
//                lsu_stall_o         - hold ex_mem and earlier stages
//                lsu_err_o           - timeout / misalign pulse
//                dbus_*              - data bus master interface
//                mem_rd_*            - result fields captured by mem_wb
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_mem_valid_i,
    input  logic [LSU_OP_WIDTH-1:0]  ex_mem_lsu_op_i,
    input  logic [XLEN-1:0]          ex_mem_addr_i,
    input  logic [XLEN-1:0]          ex_mem_sdata_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_mem_rd_idx_i,
    input  logic                     ex_mem_rd_en_i,
    output logic                     lsu_stall_o,
    output logic                     lsu_err_o,
    output logic                     dbus_req_o,
    output logic                     dbus_we_o,
    output logic [XLEN-1:0]          dbus_addr_o,
    output logic [XLEN-1:0]          dbus_wdata_o,
    output logic [3:0]               dbus_wstrb_o,
    input  logic                     dbus_gnt_i,
    input  logic                     dbus_rvalid_i,
    input  logic [XLEN-1:0]          dbus_rdata_i,
    output logic [REG_IDX_WIDTH-1:0] mem_rd_idx_o,
    output logic                     mem_rd_en_o,
    output logic [XLEN-1:0]          mem_rd_wdata_o
);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [7:0]               wait_cnt;

    logic [LSU_OP_WIDTH-1:0]  op_q;
    logic [XLEN-1:0]          addr_q;
    logic [XLEN-1:0]          sdata_q;
    logic [REG_IDX_WIDTH-1:0] rd_idx_q;
    logic                     rd_en_q;

    logic                     in_misalign;
    logic                     accept;
    logic                     timeout;
    logic                     load_wr;

    logic [XLEN-1:0]          st_wdata;
    logic [3:0]               st_wstrb;
    logic [XLEN-1:0]          ld_data;

`ifdef LSU_MISALIGN_EXC_EN
    assign in_misalign = lsu_misaligned(ex_mem_lsu_op_i[1:0], ex_mem_addr_i[1:0]);
`else
    assign in_misalign = 1'b0;
`endif

    assign accept  = (state == LSU_IDLE) && ex_mem_valid_i && !in_misalign;

    // Timeout fires in the MAX_WAIT-th WAIT cycle; an rvalid arriving in
    // that same cycle still wins and completes the op normally.
    assign timeout = (state == LSU_WAIT) && !dbus_rvalid_i &&
                     (wait_cnt == 8'(MAX_WAIT - 1));

    assign load_wr = rd_en_q && !op_q[LSU_ST_BIT];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (accept)                   state_nxt = LSU_REQ;
            LSU_REQ:  if (dbus_gnt_i)               state_nxt = LSU_WAIT;
            LSU_WAIT: if (dbus_rvalid_i || timeout) state_nxt = LSU_IDLE;
            default:                                state_nxt = LSU_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        lsu_stall_o    = 1'b0;
        lsu_err_o      = 1'b0;
        dbus_req_o     = 1'b0;
        dbus_we_o      = 1'b0;
        dbus_addr_o    = '0;
        dbus_wdata_o   = '0;
        dbus_wstrb_o   = 4'h0;
        mem_rd_idx_o   = '0;
        mem_rd_en_o    = 1'b0;
        mem_rd_wdata_o = '0;
        case (state)
            LSU_IDLE: begin
                lsu_stall_o = ex_mem_valid_i;
`ifdef LSU_MISALIGN_EXC_EN
                if (ex_mem_valid_i && in_misalign) begin
                    lsu_stall_o = 1'b0;
                    lsu_err_o   = 1'b1;
                end
`endif
            end
            LSU_REQ: begin
                lsu_stall_o = 1'b1;
                dbus_req_o  = 1'b1;
                dbus_we_o   = op_q[LSU_ST_BIT];
                dbus_addr_o = {addr_q[XLEN-1:2], 2'b00};
                if (op_q[LSU_ST_BIT]) begin
                    dbus_wdata_o = st_wdata;
                    dbus_wstrb_o = st_wstrb;
                end
            end
            LSU_WAIT: begin
                if (dbus_rvalid_i) begin
                    lsu_stall_o = 1'b0;
                    if (load_wr) begin
                        mem_rd_en_o    = 1'b1;
                        mem_rd_idx_o   = rd_idx_q;
                        mem_rd_wdata_o = ld_data;
                    end
                end else if (timeout) begin
                    lsu_err_o   = 1'b1;
                    lsu_stall_o = 1'b0;
                end else begin
                    lsu_stall_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Response wait counter, counts cycles spent in WAIT
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state != LSU_WAIT) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Latched op. The stored address already carries the lane offset the
    // access will use, so REQ and WAIT never look at ex_mem again.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            rd_idx_q <= '0;
            rd_en_q  <= 1'b0;
        end else if (accept) begin
            op_q     <= ex_mem_lsu_op_i;
            addr_q   <= {ex_mem_addr_i[XLEN-1:2],
                         lsu_lane_offset(ex_mem_lsu_op_i[1:0], ex_mem_addr_i[1:0])};
            sdata_q  <= ex_mem_sdata_i;
            rd_idx_q <= ex_mem_rd_idx_i;
            rd_en_q  <= ex_mem_rd_en_i;
        end
    end

    mem_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size        (op_q[1:0]),
        .is_unsigned (op_q[LSU_UNS_BIT]),
        .offset      (addr_q[1:0]),
        .sdata       (sdata_q),
        .rdata       (dbus_rdata_i),
        .wdata       (st_wdata),
        .wstrb       (st_wstrb),
        .ldata       (ld_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu. Directed ops drive a bus
//                slave with chosen grant/response delays; a per-cycle model
//                of the expected outputs is compared on every falling edge,
//                with literal result checks on selected ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_valid_i;
    logic [3:0]  ex_mem_lsu_op_i;
    logic [31:0] ex_mem_addr_i;
    logic [31:0] ex_mem_sdata_i;
    logic [4:0]  ex_mem_rd_idx_i;
    logic        ex_mem_rd_en_i;
    logic        lsu_stall_o;
    logic        lsu_err_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_wstrb_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic [4:0]  mem_rd_idx_o;
    logic        mem_rd_en_o;
    logic [31:0] mem_rd_wdata_o;

    always #5 clk = ~clk;

    mem_lsu #(
        .XLEN     (XLEN),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_mem_valid_i  (ex_mem_valid_i),
        .ex_mem_lsu_op_i (ex_mem_lsu_op_i),
        .ex_mem_addr_i   (ex_mem_addr_i),
        .ex_mem_sdata_i  (ex_mem_sdata_i),
        .ex_mem_rd_idx_i (ex_mem_rd_idx_i),
        .ex_mem_rd_en_i  (ex_mem_rd_en_i),
        .lsu_stall_o     (lsu_stall_o),
        .lsu_err_o       (lsu_err_o),
        .dbus_req_o      (dbus_req_o),
        .dbus_we_o       (dbus_we_o),
        .dbus_addr_o     (dbus_addr_o),
        .dbus_wdata_o    (dbus_wdata_o),
        .dbus_wstrb_o    (dbus_wstrb_o),
        .dbus_gnt_i      (dbus_gnt_i),
        .dbus_rvalid_i   (dbus_rvalid_i),
        .dbus_rdata_i    (dbus_rdata_i),
        .mem_rd_idx_o    (mem_rd_idx_o),
        .mem_rd_en_o     (mem_rd_en_o),
        .mem_rd_wdata_o  (mem_rd_wdata_o)
    );

    int tests = 0;
    int fails = 0;

    // expected outputs for the current cycle
    logic        check_en = 1'b0;
    logic        e_stall, e_err, e_req, e_we, e_rd_en, e_chkw;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_wstrb;
    logic [4:0]  e_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("stall",    32'(lsu_stall_o),   32'(e_stall));
            chk("err",      32'(lsu_err_o),     32'(e_err));
            chk("req",      32'(dbus_req_o),    32'(e_req));
            chk("rd_en",    32'(mem_rd_en_o),   32'(e_rd_en));
            chk("rd_idx",   32'(mem_rd_idx_o),  32'(e_idx));
            chk("rd_wdata", mem_rd_wdata_o,     e_rdata);
            if (e_req) begin
                chk("we",   32'(dbus_we_o),     32'(e_we));
                chk("addr", dbus_addr_o,        e_addr);
            end
            if (e_chkw) begin
                chk("wdata", dbus_wdata_o,      e_wdata);
                chk("wstrb", 32'(dbus_wstrb_o), 32'(e_wstrb));
            end
        end
    end

    // ---------------- reference model (spec arithmetic) ----------------
    function automatic logic [1:0] m_off(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd0)      return a[1:0];
        else if (size == 2'd1) return a[1:0] & 2'b10;
        else                   return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (size == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd0)      return 4'(1 << off);
        else if (size == 2'd1) return 4'(3 << off);
        else                   return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] sd);
        if (size == 2'd0)      return {24'h0, sd[7:0]} * 32'h0101_0101;
        else if (size == 2'd1) return {16'h0, sd[15:0]} * 32'h0001_0001;
        else                   return sd;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        e_stall = 0; e_err = 0; e_req = 0; e_we = 0; e_rd_en = 0; e_chkw = 0;
        e_addr = 0; e_wdata = 0; e_rdata = 0; e_wstrb = 0; e_idx = 0;
    endtask

    task automatic idle(input int n);
        ex_mem_valid_i = 0; dbus_gnt_i = 0; dbus_rvalid_i = 0;
        clear_exp();
        repeat (n) step();
    endtask

    // rdly = WAIT cycle (1-based) carrying rvalid; 0 means the slave never answers.
    // lit = literal load result (loads) or literal wdata (stores); lstrb = literal strobe.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] idx, input logic ren, input int gdly, input int rdly,
                         input logic [31:0] rd, input logic [31:0] lit, input logic [3:0] lstrb);
        logic [1:0] size, off;
        logic       st, uns, mis, wr;
        size = op[1:0]; uns = op[2]; st = op[3];
        off  = m_off(size, addr);
        mis  = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        wr   = ren && !st;

        ex_mem_valid_i = 1; ex_mem_lsu_op_i = op; ex_mem_addr_i = addr;
        ex_mem_sdata_i = sd; ex_mem_rd_idx_i = idx; ex_mem_rd_en_i = ren;
        dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = rd;
        clear_exp();
        e_stall = 1;
`ifdef LSU_MISALIGN_EXC_EN
        if (mis) begin
            e_stall = 0; e_err = 1;
            step();
            idle(0);
            return;
        end
`else
        if (mis) ; // executes on the aligned container
`endif
        step();
        for (int k = 0; k <= gdly; k++) begin
            dbus_gnt_i = (k == gdly);
            clear_exp();
            e_stall = 1; e_req = 1; e_we = st; e_addr = addr & 32'hFFFF_FFFC;
            e_chkw = st; e_wdata = m_wdata(size, sd); e_wstrb = m_strb(size, off);
            if (k == 0 && st) begin
                @(negedge clk);
                chk("lit_wdata", dbus_wdata_o, lit);
                chk("lit_wstrb", 32'(dbus_wstrb_o), 32'(lstrb));
            end
            step();
        end
        dbus_gnt_i = 0;
        clear_exp();
        if (rdly == 0) begin
            for (int j = 1; j <= MAX_WAIT; j++) begin
                e_stall = (j < MAX_WAIT);
                e_err   = (j == MAX_WAIT);
                step();
            end
        end else begin
            for (int j = 1; j <= rdly; j++) begin
                dbus_rvalid_i = (j == rdly);
                if (j == rdly) begin
                    e_stall = 0; e_rd_en = wr;
                    e_idx   = wr ? idx : 5'd0;
                    e_rdata = wr ? m_load(size, uns, off, rd) : 32'd0;
                    if (!st) begin
                        @(negedge clk);
                        chk("lit_rdata", mem_rd_wdata_o, lit);
                    end
                end else begin
                    e_stall = 1;
                end
                step();
            end
        end
        idle(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        ex_mem_valid_i = 0; ex_mem_lsu_op_i = 0; ex_mem_addr_i = 0; ex_mem_sdata_i = 0;
        ex_mem_rd_idx_i = 0; ex_mem_rd_en_i = 0;
        dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0;
        clear_exp();
        check_en = 1;
        repeat (2) @(negedge clk);          // reset state: all outputs zero
        @(posedge clk); #1;
        rst_n = 1;
        idle(2);

        // stray gnt/rvalid in IDLE are ignored
        dbus_gnt_i = 1; dbus_rvalid_i = 1; dbus_rdata_i = 32'hFFFF_FFFF;
        step();
        idle(1);

        // LB 0x1003 signed, rvalid in 2nd WAIT cycle
        do_op(4'b0000, 32'h1003, 32'h0, 5'd3, 1, 0, 2, 32'h80FF_FF00, 32'hFFFF_FF80, 4'h0);
        // LHU 0x2002, grant delayed 4 cycles (back-to-back accept)
        do_op(4'b0101, 32'h2002, 32'h0, 5'd7, 1, 4, 1, 32'h8765_4321, 32'h0000_8765, 4'h0);
        idle(1);
        // SB offset 2
        do_op(4'b1000, 32'h0000_0012, 32'h1234_56AB, 5'd9, 1, 0, 1, 32'h5555_5555, 32'hABAB_ABAB, 4'b0100);
        // SH offset 2
        do_op(4'b1001, 32'h0000_0022, 32'hAAAA_BEEF, 5'd0, 0, 1, 2, 32'h0, 32'hBEEF_BEEF, 4'b1100);
        // SW
        do_op(4'b1010, 32'h0000_0030, 32'hCAFE_F00D, 5'd0, 0, 0, 3, 32'h0, 32'hCAFE_F00D, 4'hF);
        // LH signed
        do_op(4'b0001, 32'h2000, 32'h0, 5'd12, 1, 0, 1, 32'h1234_F00D, 32'hFFFF_F00D, 4'h0);
        // LBU offset 1
        do_op(4'b0100, 32'h0041, 32'h0, 5'd31, 1, 2, 1, 32'h0000_9A00, 32'h0000_009A, 4'h0);
        // load with rd_en=0 writes nothing
        do_op(4'b0010, 32'h0050, 32'h0, 5'd4, 0, 0, 1, 32'h7777_7777, 32'h0, 4'h0);
        idle(1);
        // timeout, then a LW right behind it
        do_op(4'b0010, 32'h3000, 32'h0, 5'd5, 1, 0, 0, 32'h0, 32'h0, 4'h0);
        do_op(4'b0010, 32'h4000, 32'h0, 5'd6, 1, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0);
        idle(1);
        // misaligned LW 0x1002
        do_op(4'b0010, 32'h1002, 32'h0, 5'd8, 1, 0, 1, 32'h1122_3344, 32'h1122_3344, 4'h0);
        idle(1);

        // reset in WAIT abandons the op
        ex_mem_valid_i = 1; ex_mem_lsu_op_i = 4'b0010; ex_mem_addr_i = 32'h5000;
        ex_mem_rd_idx_i = 5'd10; ex_mem_rd_en_i = 1; dbus_rdata_i = 32'h1357_9BDF;
        clear_exp(); e_stall = 1;
        step();
        dbus_gnt_i = 1;
        clear_exp(); e_stall = 1; e_req = 1; e_addr = 32'h5000;
        step();
        dbus_gnt_i = 0;
        clear_exp(); e_stall = 1;
        step();
        rst_n = 0; ex_mem_valid_i = 0;
        clear_exp();
        step();
        rst_n = 1;
        dbus_rvalid_i = 1;                  // late response must not produce a result
        step();
        idle(1);
        do_op(4'b0010, 32'h6004, 32'h0, 5'd11, 1, 1, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'h0);
        idle(2);

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
